table_access_arbiter: RTL
=========================

Name: table_access_arbiter

Overview:
- Shares one multi-lane table instance (INPUT_RATE write lanes, OUTPUT_RATE read lanes, 1-cycle registered read) between NUM_REQ independent requesters.
- Per cycle, grants up to INPUT_RATE writes and OUTPUT_RATE reads using separate round-robin pointers.
- Drives the table's wr_en/rd_en/index/data buses directly and routes read data back to the originating requester.
- Blocks same-cycle index hazards so that table results are deterministic.

Parameters:
- NUM_REQ, 4, number of requesters.
- TABLE_SIZE, 32, table depth; IDX_W = $clog2(TABLE_SIZE).
- DATA_WIDTH, 8, entry width.
- INPUT_RATE, 2, table write lanes.
- OUTPUT_RATE, 2, table read lanes.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  request pending, one bit per requester.
- req_wr  in  NUM_REQ  1 = write, 0 = read.
- req_index  in  NUM_REQ*IDX_W  target index, requester i at slice i.
- req_wdata  in  NUM_REQ*DATA_WIDTH  write data.
- req_ready  out  NUM_REQ  grant this cycle (combinational).
- rsp_valid  out  NUM_REQ  read data valid (registered).
- rsp_data  out  NUM_REQ*DATA_WIDTH  read data for requester i.
- tbl_wr_en  out  1  to table wr_en.
- tbl_rd_en  out  1  to table rd_en.
- tbl_index_wr  out  INPUT_RATE*IDX_W  to table index_wr.
- tbl_data_wr  out  INPUT_RATE*DATA_WIDTH  to table data_wr.
- tbl_index_rd  out  OUTPUT_RATE*IDX_W  to table index_rd.
- tbl_data_rd  in  OUTPUT_RATE*DATA_WIDTH  from table data_rd, valid 1 cycle after tbl_rd_en.

Behaviour:
- Handshake: a transfer occurs when req_valid[i] & req_ready[i]. Requesters hold valid, wr, index and wdata stable until ready. req_ready never asserts without req_valid.
- Write arbitration:
  - Scan requesters with valid & wr, starting at wr_ptr and wrapping modulo NUM_REQ.
  - Grant up to INPUT_RATE of them. The k-th grantee drives write lane k.
  - A candidate whose index equals an already-granted write index this cycle is skipped (deferred).
- Read arbitration:
  - Scan requesters with valid & ~wr, starting at rd_ptr.
  - Grant up to OUTPUT_RATE. The k-th grantee drives read lane k.
  - A read whose index matches any write granted this cycle is skipped, so it never returns stale data.
  - Duplicate read indices are allowed.
- Unused lanes drive index 0 and data 0.
- tbl_wr_en = any write granted; tbl_rd_en = any read granted. All tbl_* outputs are combinational from arbitration.
- Pointer update at the clock edge:
  - wr_ptr moves to (last granted writer + 1) mod NUM_REQ.
  - rd_ptr moves likewise for readers.
  - A pointer is unchanged when its type has no grants.
- Fairness: every requester that holds valid is granted within NUM_REQ cycles, provided it has no persistent index conflict.
- Response path:
  - Register the grantee id and lane for each read lane granted.
  - Next cycle, rsp_valid[id] = 1 and rsp_data[id] = tbl_data_rd lane slice.
  - rsp_valid is a single-cycle pulse.
  - Read latency from handshake to rsp_valid is exactly 1 cycle.
  - Back-to-back reads from the same requester give back-to-back pulses.
- Simultaneous events:
  - Read and write to different indices in the same cycle are both granted.
  - A requester can hold at most one outstanding transfer per cycle, since req_wr selects its type.
- Reset (rst = 0, asynchronous):
  - wr_ptr = rd_ptr = 0; rsp_valid = 0; rsp_data = 0; response pipeline cleared.
  - Combinational grants are forced to 0, so req_ready = 0 and tbl_wr_en = tbl_rd_en = 0.
  - Reset mid-operation drops in-flight read responses. No rsp_valid is produced for them after release.
- Widths: indices beyond TABLE_SIZE-1 are passed through unchanged; range checking is the requester's responsibility.

Test Plan:
- Reset: hold rst = 0 with all req_valid = 1 -> req_ready = 0, tbl_wr_en = tbl_rd_en = 0, rsp_valid = 0. Release -> first grants go to requesters 0 and 1 for both types.
- Write lanes: requesters 0–3 all write (indices 3, 7, 9, 12; data 0xA1–0xA4), held valid -> cycle 1 grants 0 and 1, cycle 2 grants 2 and 3. A later read of each index returns the written data.
- Write-write hazard: requesters 0 and 1 both write index 5 (0x11, 0x22) -> only requester 0 granted in cycle 1, requester 1 in cycle 2. A final read of index 5 returns 0x22.
- Read-after-write hazard: requester 0 writes index 4 = 0x55 while requester 2 reads index 4 (old 0x00) in the same cycle -> the read is deferred one cycle, and rsp_data[2] = 0x55 with rsp_valid[2] one cycle after its ready.
- Round-robin fairness: all 4 requesters read continuously for 8 cycles -> grant pairs {0,1}, {2,3}, {0,1}... Each requester gets 4 rsp_valid pulses carrying correct data.
- Reset mid-read: read granted at cycle N, rst asserted before edge N+1 -> no rsp_valid at N+1. After release, wr_ptr = rd_ptr = 0.

Source files
------------

// File: rtl/table_access_arbiter.sv
// table_access_arbiter: shares one multi-lane table between NUM_REQ requesters.
// Round-robin grants of up to INPUT_RATE writes and OUTPUT_RATE reads per cycle,
// with same-cycle index hazards screened out, and read data routed back one cycle later.
module table_access_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned TABLE_SIZE  = 32,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned INPUT_RATE  = 2,
    parameter int unsigned OUTPUT_RATE = 2,
    localparam int unsigned IDX_W      = $clog2(TABLE_SIZE)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ-1:0]                req_wr,
    input  logic [NUM_REQ*IDX_W-1:0]          req_index,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_wdata,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic [NUM_REQ-1:0]                rsp_valid,
    output logic [NUM_REQ*DATA_WIDTH-1:0]     rsp_data,
    output logic                              tbl_wr_en,
    output logic                              tbl_rd_en,
    output logic [INPUT_RATE*IDX_W-1:0]       tbl_index_wr,
    output logic [INPUT_RATE*DATA_WIDTH-1:0]  tbl_data_wr,
    output logic [OUTPUT_RATE*IDX_W-1:0]      tbl_index_rd,
    input  logic [OUTPUT_RATE*DATA_WIDTH-1:0] tbl_data_rd
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]             wr_ptr;
    logic [PTR_W-1:0]             wr_ptr_nxt;
    logic [PTR_W-1:0]             rd_ptr;
    logic [PTR_W-1:0]             rd_ptr_nxt;
    logic [OUTPUT_RATE-1:0]       lane_vld;
    logic [OUTPUT_RATE-1:0]       lane_vld_nxt;
    logic [OUTPUT_RATE*PTR_W-1:0] lane_id;
    logic [OUTPUT_RATE*PTR_W-1:0] lane_id_nxt;
    int unsigned                  wr_cnt;
    int unsigned                  rd_cnt;
    int unsigned                  cand;
    logic                         hit;

    // Round-robin write scan, then read scan, each skipping same-cycle index hazards
    always_comb begin
        req_ready    = '0;
        tbl_index_wr = '0;
        tbl_data_wr  = '0;
        tbl_index_rd = '0;
        wr_ptr_nxt   = wr_ptr;
        rd_ptr_nxt   = rd_ptr;
        lane_vld_nxt = '0;
        lane_id_nxt  = '0;
        wr_cnt       = 0;
        rd_cnt       = 0;
        cand         = 0;
        hit          = 1'b0;

        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand = (32'(wr_ptr) + off) % NUM_REQ;
            hit  = 1'b0;
            for (int unsigned k = 0; k < INPUT_RATE; k++) begin
                if (k < wr_cnt &&
                    tbl_index_wr[k*IDX_W +: IDX_W] == req_index[cand*IDX_W +: IDX_W])
                    hit = 1'b1;
            end
            if (rst && req_valid[cand] && req_wr[cand] && wr_cnt < INPUT_RATE && !hit) begin
                req_ready[cand]                                 = 1'b1;
                tbl_index_wr[wr_cnt*IDX_W +: IDX_W]             = req_index[cand*IDX_W +: IDX_W];
                tbl_data_wr[wr_cnt*DATA_WIDTH +: DATA_WIDTH]    = req_wdata[cand*DATA_WIDTH +: DATA_WIDTH];
                wr_cnt                                          = wr_cnt + 1;
                wr_ptr_nxt                                      = PTR_W'((cand + 1) % NUM_REQ);
            end
        end

        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand = (32'(rd_ptr) + off) % NUM_REQ;
            hit  = 1'b0;
            for (int unsigned k = 0; k < INPUT_RATE; k++) begin
                if (k < wr_cnt &&
                    tbl_index_wr[k*IDX_W +: IDX_W] == req_index[cand*IDX_W +: IDX_W])
                    hit = 1'b1;
            end
            if (rst && req_valid[cand] && !req_wr[cand] && rd_cnt < OUTPUT_RATE && !hit) begin
                req_ready[cand]                      = 1'b1;
                tbl_index_rd[rd_cnt*IDX_W +: IDX_W]  = req_index[cand*IDX_W +: IDX_W];
                lane_vld_nxt[rd_cnt]                 = 1'b1;
                lane_id_nxt[rd_cnt*PTR_W +: PTR_W]   = PTR_W'(cand);
                rd_cnt                               = rd_cnt + 1;
                rd_ptr_nxt                           = PTR_W'((cand + 1) % NUM_REQ);
            end
        end

        tbl_wr_en = (wr_cnt != 0);
        tbl_rd_en = (rd_cnt != 0);
    end

    // Pointers and read-lane ownership; reset drops any in-flight response
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            lane_vld <= '0;
            lane_id  <= '0;
        end else begin
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt;
            lane_vld <= lane_vld_nxt;
            lane_id  <= lane_id_nxt;
        end
    end

    // Steer each returning read lane to the requester that owns it
    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        for (int unsigned k = 0; k < OUTPUT_RATE; k++) begin
            if (lane_vld[k]) begin
                rsp_valid[lane_id[k*PTR_W +: PTR_W]] = 1'b1;
                rsp_data[32'(lane_id[k*PTR_W +: PTR_W])*DATA_WIDTH +: DATA_WIDTH] =
                    tbl_data_rd[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule
